// File: rtl/spi_pkg.sv
// Shared types for the SPI word receiver: FSM state encoding and the
// CPOL/CPHA to sampling-edge mapping.
package spi_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    typedef enum logic {
        EDGE_RISE = 1'b0,
        EDGE_FALL = 1'b1
    } edge_t;

    // The leading edge rises when CPOL=0; CPHA=1 moves sampling to the trailing edge.
    function automatic edge_t sample_edge(input logic cpol, input logic cpha);
        return (cpol ^ cpha) ? EDGE_FALL : EDGE_RISE;
    endfunction

endpackage

// File: rtl/spi_word_rx_if.sv
// SPI pins plus the receive-word stream and the MISO return word.
// Handshake: a word transfers on a clk edge where out_valid and out_ready are both high;
// out_valid stays high and out_data stays stable until that transfer happens.
interface spi_word_rx_if #(
    parameter int WIDTH = 16
);
    logic             nCS;
    logic             SCK;
    logic             MOSI;
    logic             MISO;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] tx_data;

    modport master (
        output nCS, SCK, MOSI, out_ready, tx_data,
        input  MISO, out_data, out_valid
    );

    modport slave (
        input  nCS, SCK, MOSI, out_ready, tx_data,
        output MISO, out_data, out_valid
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO succeeds
// only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int  WIDTH = 16,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW + 1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/spi_word_rx.sv
// SPI slave receiver: oversamples nCS/SCK/MOSI with clk, assembles MSB-first
// words into a FIFO and returns tx_data on MISO.
module spi_word_rx
    import spi_pkg::*;
#(
    parameter int  WIDTH = 16,
    parameter int  DEPTH = 4,
    parameter int  CPOL  = 0,
    parameter int  CPHA  = 0,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    spi_word_rx_if.slave  bus,
    output logic [LW-1:0] level,
    output logic          overflow,
    input  logic          ovf_clr,
    output logic          frame_err,
    output state_t        dbg_state
);
    localparam int    CW        = $clog2(WIDTH);
    localparam edge_t SAMP_EDGE = sample_edge(CPOL != 0, CPHA != 0);
    localparam logic  SCK_IDLE  = (CPOL != 0);

    logic [2:0] ncs_s;
    logic [2:0] sck_s;
    logic [1:0] mosi_s;

    // nCS stages reset low: a frame already open at reset is not seen as a new
    // select, so shifting resumes only after a later falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ncs_s  <= '0;
            sck_s  <= {3{SCK_IDLE}};
            mosi_s <= '0;
        end else begin
            ncs_s  <= {ncs_s[1:0], bus.nCS};
            sck_s  <= {sck_s[1:0], bus.SCK};
            mosi_s <= {mosi_s[0], bus.MOSI};
        end
    end

    logic ncs_fall, ncs_rise, sck_rise, sck_fall, samp_evt, drv_evt, mosi_bit;

    assign ncs_fall = ncs_s[2] & ~ncs_s[1];
    assign ncs_rise = ~ncs_s[2] & ncs_s[1];
    assign sck_rise = ~sck_s[2] & sck_s[1];
    assign sck_fall = sck_s[2] & ~sck_s[1];
    assign mosi_bit = mosi_s[1];
    assign samp_evt = (SAMP_EDGE == EDGE_RISE) ? sck_rise : sck_fall;
    assign drv_evt  = (SAMP_EDGE == EDGE_RISE) ? sck_fall : sck_rise;

    state_t           state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-2:0] rx_sr;
    logic [WIDTH-1:0] tx_sr;
    logic             miso_q;
    logic             word_done;
    logic [WIDTH-1:0] rx_word;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    assign rx_word   = {rx_sr, mosi_bit};
    assign word_done = (state == ST_SHIFT) && !ncs_rise && samp_evt &&
                       (bit_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            miso_q    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ncs_fall) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                        // CPHA=0 must present the MSB before the first sampling edge.
                        if (CPHA == 0) begin
                            miso_q <= bus.tx_data[WIDTH-1];
                            tx_sr  <= {bus.tx_data[WIDTH-2:0], 1'b0};
                        end else begin
                            tx_sr  <= bus.tx_data;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (ncs_rise) begin
                        state     <= ST_IDLE;
                        bit_cnt   <= '0;
                        miso_q    <= 1'b0;
                        frame_err <= (bit_cnt != '0);
                    end else if (samp_evt) begin
                        rx_sr <= rx_word[WIDTH-2:0];
                        if (word_done) begin
                            bit_cnt <= '0;
                            tx_sr   <= bus.tx_data;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (drv_evt) begin
                        miso_q <= tx_sr[WIDTH-1];
                        tx_sr  <= {tx_sr[WIDTH-2:0], 1'b0};
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign pop       = bus.out_ready & ~fifo_empty;
    assign bus.out_valid = ~fifo_empty;
    assign bus.MISO  = miso_q;
    assign dbg_state = state;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (word_done),
        .push_data (rx_word),
        .pop       (pop),
        .head      (bus.out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    // A dropped word sets the flag even if a clear arrives in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (word_done && fifo_full && !pop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule
